// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   SEG_TABLE : 16-entry hex-to-segment table, active-high, bit order gfedcba
//   hex2seg   : decode one nibble into its segment pattern
package seg7_pkg;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Terminal-count tick generator for the digit scan.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset, clears the count
//   en_i   : count enable; the count holds while low
//   tick_o : high in the cycle the count sits at DIV-1 with en_i high
module seg7_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver with frame-synchronous data update.
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   en                 : scan enable; low freezes the scan and darkens all digits
//   load               : strobe capturing data/blank/dp into the pending register
//   data, blank, dp    : nibble per digit, forced blank per digit, decimal point per digit
//   an, seg, dp_out    : registered digit enables, segments (gfedcba), decimal point
//   digit_idx          : current scan digit
//   frame_done         : one-cycle pulse in the cycle digit_idx wraps to 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       data,
  input  logic [NUM_DIGITS-1:0]         blank,
  input  logic [NUM_DIGITS-1:0]         dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int   IW  = $clog2(NUM_DIGITS);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic                    tick, wrap;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   pend_blank_q, act_blank_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic                    out_en_q;
  logic                    fd_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  // Decode scratch
  logic [4*NUM_DIGITS-1:0] upper;
  logic [3:0]              nib;
  logic                    suppress, lit;
  logic [NUM_DIGITS-1:0]   an_raw;
  logic [6:0]              seg_raw;
  logic                    dp_raw;

  seg7_prescaler #(
    .DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .tick_o(tick)
  );

  assign wrap = tick && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);
  end

  always_comb begin
    // Shifting the current digit down to bit 0 leaves exactly this nibble and
    // every higher one, so a zero result means "this and all above are 0".
    upper    = act_data_q >> {idx_q, 2'b00};
    nib      = upper[3:0];
    suppress = (LZ_SUPPRESS != 0) && (idx_q != '0) && (upper == '0);
    lit      = out_en_q && en && !act_blank_q[idx_q] && !suppress;
    an_raw   = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_raw  = lit ? hex2seg(nib) : '0;
    dp_raw   = lit && act_dp_q[idx_q];
    an_d     = an_raw ^ {NUM_DIGITS{POL}};
    seg_d    = seg_raw ^ {7{POL}};
    dp_d     = dp_raw ^ POL;
  end

  // out_en_q keeps the outputs dark for one extra cycle after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      act_data_q   <= '0;
      act_blank_q  <= '0;
      act_dp_q     <= '0;
      out_en_q     <= 1'b0;
      fd_q         <= 1'b0;
      an_q         <= {NUM_DIGITS{POL}};
      seg_q        <= {7{POL}};
      dp_q         <= POL;
    end else begin
      idx_q    <= idx_d;
      out_en_q <= 1'b1;
      fd_q     <= wrap;
      if (load) begin
        pend_data_q  <= data;
        pend_blank_q <= blank;
        pend_dp_q    <= dp;
      end
      if (wrap) begin
        act_data_q  <= load ? data  : pend_data_q;
        act_blank_q <= load ? blank : pend_blank_q;
        act_dp_q    <= load ? dp    : pend_dp_q;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_out     = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, load;
  logic [15:0] data;
  logic [3:0]  blank, dp;

  // u0: plain, u1: leading-zero suppression, u2: active-low outputs
  logic [3:0] an0, an1, an2;
  logic [6:0] seg0, seg1, seg2;
  logic       dpo0, dpo1, dpo2;
  logic [1:0] idx0, idx1, idx2;
  logic       fd0, fd1, fd2;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0), .LZ_SUPPRESS(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .blank(blank), .dp(dp),
    .an(an0), .seg(seg0), .dp_out(dpo0), .digit_idx(idx0), .frame_done(fd0));

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0), .LZ_SUPPRESS(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .blank(blank), .dp(dp),
    .an(an1), .seg(seg1), .dp_out(dpo1), .digit_idx(idx1), .frame_done(fd1));

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1), .LZ_SUPPRESS(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .blank(blank), .dp(dp),
    .an(an2), .seg(seg2), .dp_out(dpo2), .digit_idx(idx2), .frame_done(fd2));

  typedef struct {
    int         sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic [1:0] idx;
    bit         care;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic exp_t mk_idle(input int sel, input logic [1:0] idx, input bit care);
    exp_t e;
    bit al = (sel == 2);
    e.sel  = sel;
    e.an   = al ? 4'hF : 4'h0;
    e.seg  = al ? 7'h7F : 7'h00;
    e.dp   = al;
    e.fd   = 1'b0;
    e.idx  = idx;
    e.care = care;
    return e;
  endfunction

  function automatic exp_t mk_digit(input int sel, input int d, input logic [15:0] dat,
                                    input logic [3:0] blk, input logic [3:0] dpv,
                                    input logic [1:0] idx, input logic fd);
    exp_t e;
    bit al = (sel == 2);
    bit lz = (sel == 1);
    logic [15:0] up = dat >> (4 * d);
    bit lit = (((blk >> d) & 4'h1) == 4'h0) && !(lz && d > 0 && up == 16'h0);
    logic [3:0] a = lit ? 4'(1 << d) : 4'h0;
    logic [6:0] s = lit ? ref_seg(up[3:0]) : 7'h00;
    logic       p = lit && (((dpv >> d) & 4'h1) != 4'h0);
    e.sel  = sel;
    e.an   = al ? ~a : a;
    e.seg  = al ? ~s : s;
    e.dp   = al ? ~p : p;
    e.fd   = fd;
    e.idx  = idx;
    e.care = 1'b1;
    return e;
  endfunction

  // One digit is shown for 4 cycles; digit_idx moves on during the 4th.
  task automatic push_digit(input int sel, input int d, input logic [15:0] dat,
                            input logic [3:0] blk, input logic [3:0] dpv);
    for (int k = 0; k < 4; k++)
      sb.push_back(mk_digit(sel, d, dat, blk, dpv,
                            (k < 3) ? 2'(d) : 2'((d + 1) % 4), (k == 3 && d == 3)));
  endtask

  task automatic push_frame(input int sel, input logic [15:0] dat,
                            input logic [3:0] blk, input logic [3:0] dpv);
    for (int d = 0; d < 4; d++) push_digit(sel, d, dat, blk, dpv);
  endtask

  task automatic step(input int n);
    exp_t e;
    logic [3:0] oa; logic [6:0] os; logic od, of; logic [1:0] oi;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        check_val("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        case (e.sel)
          1:       begin oa = an1; os = seg1; od = dpo1; of = fd1; oi = idx1; end
          2:       begin oa = an2; os = seg2; od = dpo2; of = fd2; oi = idx2; end
          default: begin oa = an0; os = seg0; od = dpo0; of = fd0; oi = idx0; end
        endcase
        check_val($sformatf("an u%0d", e.sel), 32'(oa), 32'(e.an));
        if (e.care) begin
          check_val($sformatf("seg u%0d", e.sel), 32'(os), 32'(e.seg));
          check_val($sformatf("dp_out u%0d", e.sel), 32'(od), 32'(e.dp));
        end
        check_val($sformatf("frame_done u%0d", e.sel), 32'(of), 32'(e.fd));
        check_val($sformatf("digit_idx u%0d", e.sel), 32'(oi), 32'(e.idx));
      end
    end
  endtask

  task automatic sync_frame();
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (fd0) found = 1'b1;
    end
    check_val("frame_sync", 32'(found), 32'd1);
  endtask

  task automatic wait_idx(input logic [1:0] v);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (idx0 == v) found = 1'b1;
    end
    check_val("idx_wait", 32'(found), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] dat, input logic [3:0] blk, input logic [3:0] dpv);
    data = dat; blank = blk; dp = dpv; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; blank = '0; dp = '0;
    @(negedge clk); @(negedge clk);

    // Reset state on all three variants
    sb.push_back(mk_idle(0, 2'd0, 1'b1)); step(1);
    sb.push_back(mk_idle(1, 2'd0, 1'b1)); step(1);
    sb.push_back(mk_idle(2, 2'd0, 1'b1)); step(1);
    rst = 1'b0; en = 1'b1;
    sb.push_back(mk_idle(0, 2'd0, 1'b1)); step(1);

    // Basic frame, two consecutive frames to see frame_done every 16 cycles
    do_load(16'h12AF, 4'b0000, 4'b0000);
    sync_frame();
    push_frame(0, 16'h12AF, 4'b0000, 4'b0000);
    push_frame(0, 16'h12AF, 4'b0000, 4'b0000);
    step(32);

    // Mid-frame load at digit 1: rest of frame old, new from digit 0
    wait_idx(2'd1);
    data = 16'h1111; blank = '0; dp = '0; load = 1'b1;
    for (int d = 1; d < 4; d++) push_digit(0, d, 16'h12AF, 4'b0000, 4'b0000);
    push_frame(0, 16'h1111, 4'b0000, 4'b0000);
    step(1);
    load = 1'b0;
    step(27);

    // Leading-zero suppression
    do_load(16'h0005, 4'b0000, 4'b0000);
    sync_frame(); push_frame(1, 16'h0005, 4'b0000, 4'b0000); step(16);
    do_load(16'h0000, 4'b0000, 4'b0000);
    sync_frame(); push_frame(1, 16'h0000, 4'b0000, 4'b0000); step(16);
    do_load(16'h0500, 4'b0000, 4'b0000);
    sync_frame(); push_frame(1, 16'h0500, 4'b0000, 4'b0000); step(16);

    // Forced blank with dp on the blanked digit, then visible decimal points
    do_load(16'h12AF, 4'b0100, 4'b0100);
    sync_frame(); push_frame(0, 16'h12AF, 4'b0100, 4'b0100); step(16);
    do_load(16'h12AF, 4'b0000, 4'b1001);
    sync_frame(); push_frame(0, 16'h12AF, 4'b0000, 4'b1001); step(16);

    // Scan enable dropped for 10 cycles mid-digit
    sync_frame();
    repeat (2) sb.push_back(mk_digit(0, 0, 16'h12AF, 4'b0000, 4'b1001, 2'd0, 1'b0));
    step(2);
    en = 1'b0;
    repeat (10) sb.push_back(mk_idle(0, 2'd0, 1'b0));
    step(10);
    en = 1'b1;
    sb.push_back(mk_digit(0, 0, 16'h12AF, 4'b0000, 4'b1001, 2'd0, 1'b0));
    sb.push_back(mk_digit(0, 0, 16'h12AF, 4'b0000, 4'b1001, 2'd1, 1'b0));
    for (int d = 1; d < 4; d++) push_digit(0, d, 16'h12AF, 4'b0000, 4'b1001);
    step(14);

    // Active-low variant, reset mid-frame with pending data outstanding
    sync_frame();
    repeat (2) sb.push_back(mk_digit(2, 0, 16'h12AF, 4'b0000, 4'b1001, 2'd0, 1'b0));
    step(2);
    data = 16'h8888; blank = '0; dp = '0; load = 1'b1;
    sb.push_back(mk_digit(2, 0, 16'h12AF, 4'b0000, 4'b1001, 2'd0, 1'b0));
    step(1);
    load = 1'b0; rst = 1'b1;
    repeat (2) sb.push_back(mk_idle(2, 2'd0, 1'b1));
    step(2);
    rst = 1'b0;
    sb.push_back(mk_idle(2, 2'd0, 1'b1));
    step(1);
    repeat (2) sb.push_back(mk_digit(2, 0, 16'h0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
    sb.push_back(mk_digit(2, 0, 16'h0000, 4'b0000, 4'b0000, 2'd1, 1'b0));
    for (int d = 1; d < 4; d++) push_digit(2, d, 16'h0000, 4'b0000, 4'b0000);
    push_frame(2, 16'h0000, 4'b0000, 4'b0000);
    step(31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
